pe_row_sequencer: RTL and testbench
===================================

# pe_row_sequencer

Controller that sequences one PE row through a multi-pass dot product. Each pass fetches one activation/weight tile from the tile buffer and strobes it into the row. It feeds the previous pass's psum back into the row's psum input and captures the row's psum output after the row pipeline latency. After the last pass it presents the result on a valid/ready port. It sits between the tile buffer / layer control and the PE row datapath; tile data goes straight from the buffer to the row, and this block drives only control signals and the psum path.

## Interface
- WIDTH, 14, psum width; equals the row's psum width
- PIPE_LAT, 11, cycles from load strobe to valid psum at row output; must be >= 1
- PASS_W, 8, width of pass count and tile index
- clk_in  in  1  clock, rising edge
- rst_in  in  1  asynchronous, active-high reset
- start_in  in  1  start a job; sampled only in IDLE
- num_pass_in  in  PASS_W  number of passes; latched with start_in
- busy_out  out  1  high in any state except IDLE
- tile_req_out  out  1  requests the tile at tile_idx_out
- tile_idx_out  out  PASS_W  index of the tile being requested (the current pass)
- tile_valid_in  in  1  buffer is presenting the requested tile on the row inputs
- row_load_out  out  1  row latches activation/weight/psum this cycle
- psum_to_row_out  out  WIDTH  drives the row's psum input
- psum_from_row_in  in  WIDTH  row's final psum output
- result_out  out  WIDTH  final accumulated psum
- result_valid_out  out  1  result available
- result_ready_in  in  1  consumer accepts result

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE
  - start_in=1 and num_pass_in!=0: latch num_pass, clear pass_cnt and acc, go to REQ.
  - start_in=1 and num_pass_in=0: clear acc, go to DONE; result is 0.
- REQ
  - tile_req_out=1 and tile_idx_out=pass_cnt.
  - If tile_valid_in=1 in the same cycle: row_load_out=1, wait_cnt<=PIPE_LAT-1, go to WAIT.
  - Otherwise stay in REQ (stall).
- WAIT
  - If wait_cnt!=0: decrement it.
  - If wait_cnt==0: acc<=psum_from_row_in.
    - If pass_cnt==num_pass-1: go to DONE.
    - Else: pass_cnt++ and go to REQ.
- DONE
  - result_valid_out=1 and result_out=acc.
  - result_ready_in=1 completes the handshake and returns to IDLE.
- psum_to_row_out = acc at all times; acc changes only on a capture, so the value is stable through the load cycle.
- No arithmetic in this block. Accumulation happens inside the row. acc is a plain WIDTH-bit register; wrap behaviour is defined by the row.
- start_in outside IDLE is ignored, including in the DONE handshake cycle.
- tile_valid_in outside REQ is ignored.
- row_load_out is never high outside REQ.

## Timing
- Reset values: all outputs 0, state IDLE, acc/pass_cnt/wait_cnt 0.
- Reset asserted mid-job aborts the job immediately; no result is produced.
- start sampled at edge of cycle 0: REQ in cycle 1.
- With zero stall, each pass takes PIPE_LAT+1 cycles. psum_from_row_in is sampled in the cycle PIPE_LAT after the load cycle.
- result_valid_out first high in cycle 1+N·(PIPE_LAT+1), plus total REQ stall cycles.
- num_pass=0: result_valid_out high in cycle 1.
- result_valid_out and result_out are held until the handshake completes.
- IDLE reached the cycle after the handshake. A new start can be sampled in that IDLE cycle.

## Configuration
- PE_ROW_SEQ_PERF_EN defined: adds two outputs, each 32 bits, saturating at all-ones, cleared by reset and on each accepted start:
  - perf_busy_cycles_out counts cycles with busy_out=1.
  - perf_stall_cycles_out counts REQ cycles with tile_valid_in=0.
- PE_ROW_SEQ_PERF_EN undefined: these ports and their logic are absent; all other behaviour is identical.

## Structure
- pe_row_pkg holds:
  - the state enum (IDLE/REQ/WAIT/DONE)
  - WIDTH and PIPE_LAT defaults shared with the PE row
  - the perf counter width constant (32)
- One sub-module, pe_row_seq_perf, holds the two saturating counters. It is instantiated only under PE_ROW_SEQ_PERF_EN.

## Test plan
- PIPE_LAT=11, num_pass=1, tile_valid tied 1, row model returns psum_in+5: row_load in cycle 1; result_valid in cycle 13 with result 5.
- num_pass=3, row model adds 7 per pass, tile_valid tied 1: tile_idx sequence 0,1,2; psum_to_row_out 0,7,14 at the loads; result 21 in cycle 37.
- num_pass=2, tile_valid held low 4 cycles in each REQ: result_valid delayed by 8 cycles; perf_stall_cycles_out=8 with PE_ROW_SEQ_PERF_EN.
- result_ready low 5 cycles in DONE, start_in pulsed during DONE: result held stable; start ignored; IDLE one cycle after ready.
- num_pass=0: result_valid in cycle 1 with result 0; no tile_req or row_load ever asserted.
- rst_in pulsed during WAIT of pass 2: all outputs 0 asynchronously; a new start afterwards runs from pass 0 with acc 0.

Source files
------------

// File: rtl/pe_row_pkg.sv
// rtl/pe_row_pkg.sv - shared types and defaults for the PE row sequencer
// Holds the sequencer state encoding, datapath defaults shared with the PE row,
// and the width of the optional performance counters.
package pe_row_pkg;

   localparam int WIDTH_DEF    = 14;
   localparam int PIPE_LAT_DEF = 11;
   localparam int PASS_W_DEF   = 8;
   localparam int PERF_W       = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } seq_state_t;

endpackage

// File: rtl/pe_row_sequencer_if.sv
// rtl/pe_row_sequencer_if.sv - control, tile and result signals of the PE row sequencer
// master: the sequencer side. slave: tile buffer / row / consumer side.
// With PE_ROW_SEQ_PERF_EN defined the two performance counter outputs are added.
interface pe_row_sequencer_if
   import pe_row_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int PASS_W = PASS_W_DEF
);
   logic              start_in;
   logic [PASS_W-1:0] num_pass_in;
   logic              busy_out;
   logic              tile_req_out;
   logic [PASS_W-1:0] tile_idx_out;
   logic              tile_valid_in;
   logic              row_load_out;
   logic [WIDTH-1:0]  psum_to_row_out;
   logic [WIDTH-1:0]  psum_from_row_in;
   logic [WIDTH-1:0]  result_out;
   logic              result_valid_out;
   logic              result_ready_in;
`ifdef PE_ROW_SEQ_PERF_EN
   logic [PERF_W-1:0] perf_busy_cycles_out;
   logic [PERF_W-1:0] perf_stall_cycles_out;
`endif

   modport master (
      input  start_in, num_pass_in, tile_valid_in, psum_from_row_in, result_ready_in,
      output busy_out, tile_req_out, tile_idx_out, row_load_out, psum_to_row_out,
             result_out, result_valid_out
`ifdef PE_ROW_SEQ_PERF_EN
      , output perf_busy_cycles_out, perf_stall_cycles_out
`endif
   );

   modport slave (
      output start_in, num_pass_in, tile_valid_in, psum_from_row_in, result_ready_in,
      input  busy_out, tile_req_out, tile_idx_out, row_load_out, psum_to_row_out,
             result_out, result_valid_out
`ifdef PE_ROW_SEQ_PERF_EN
      , input perf_busy_cycles_out, perf_stall_cycles_out
`endif
   );

endinterface

// File: rtl/pe_row_seq_perf.sv
// rtl/pe_row_seq_perf.sv - saturating busy/stall cycle counters (used only with PE_ROW_SEQ_PERF_EN)
module pe_row_seq_perf
   import pe_row_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_busy,
   input  logic              i_stall,
   output logic [PERF_W-1:0] o_busy_cycles,
   output logic [PERF_W-1:0] o_stall_cycles
);
   localparam logic [PERF_W-1:0] ONE = PERF_W'(1);

   logic [PERF_W-1:0] r_busy_cnt;
   logic [PERF_W-1:0] r_stall_cnt;

   // Busy-cycle counter: cleared on an accepted start, sticks at all-ones.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                              r_busy_cnt <= '0;
      else if (i_clear)                       r_busy_cnt <= '0;
      else if (i_busy && (r_busy_cnt != '1))  r_busy_cnt <= r_busy_cnt + ONE;
   end

   // Stall-cycle counter: counts REQ cycles without a tile, sticks at all-ones.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                               r_stall_cnt <= '0;
      else if (i_clear)                        r_stall_cnt <= '0;
      else if (i_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + ONE;
   end

   assign o_busy_cycles  = r_busy_cnt;
   assign o_stall_cycles = r_stall_cnt;

endmodule

// File: rtl/pe_row_sequencer.sv
// rtl/pe_row_sequencer.sv - sequences one PE row through a multi-pass dot product
// Fetches one tile per pass, strobes it into the row, feeds the previous psum
// back and captures the row output PIPE_LAT cycles after the load.
// Optional feature macro: PE_ROW_SEQ_PERF_EN (busy/stall performance counters).
module pe_row_sequencer
   import pe_row_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int PIPE_LAT = PIPE_LAT_DEF,
   parameter int PASS_W   = PASS_W_DEF
)
(
   input  logic clk_in,
   input  logic rst_in,
   pe_row_sequencer_if.master bus
);
   localparam int WAIT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(PIPE_LAT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [PASS_W-1:0] PASS_ONE  = PASS_W'(1);

   seq_state_t        r_state;
   logic [PASS_W-1:0] r_num_pass;
   logic [PASS_W-1:0] r_pass_cnt;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [WIDTH-1:0]  r_acc;

   seq_state_t        w_state_nxt;
   logic [PASS_W-1:0] w_num_pass_nxt;
   logic [PASS_W-1:0] w_pass_cnt_nxt;
   logic [WAIT_W-1:0] w_wait_cnt_nxt;
   logic [WIDTH-1:0]  w_acc_nxt;
   logic              w_tile_req;
   logic              w_row_load;
   logic              w_result_valid;
   logic              w_start_acc;

   // State and job registers; reset aborts any job in flight.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state    <= ST_IDLE;
         r_num_pass <= '0;
         r_pass_cnt <= '0;
         r_wait_cnt <= '0;
         r_acc      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_num_pass <= w_num_pass_nxt;
         r_pass_cnt <= w_pass_cnt_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         r_acc      <= w_acc_nxt;
      end
   end

   // Next-state and control decode; acc only moves on a start or a row capture.
   always_comb begin
      w_state_nxt    = r_state;
      w_num_pass_nxt = r_num_pass;
      w_pass_cnt_nxt = r_pass_cnt;
      w_wait_cnt_nxt = r_wait_cnt;
      w_acc_nxt      = r_acc;
      w_tile_req     = 1'b0;
      w_row_load     = 1'b0;
      w_result_valid = 1'b0;
      w_start_acc    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start_in) begin
               w_start_acc    = 1'b1;
               w_acc_nxt      = '0;
               w_pass_cnt_nxt = '0;
               w_wait_cnt_nxt = '0;
               w_num_pass_nxt = bus.num_pass_in;
               // A zero-pass job has nothing to fetch and reports 0 directly.
               w_state_nxt    = (bus.num_pass_in != '0) ? ST_REQ : ST_DONE;
            end
         end
         ST_REQ: begin
            w_tile_req = 1'b1;
            if (bus.tile_valid_in) begin
               w_row_load     = 1'b1;
               w_wait_cnt_nxt = WAIT_LOAD;
               w_state_nxt    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_wait_cnt != '0) begin
               w_wait_cnt_nxt = r_wait_cnt - WAIT_ONE;
            end else begin
               w_acc_nxt = bus.psum_from_row_in;
               if (r_pass_cnt == (r_num_pass - PASS_ONE)) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_pass_cnt_nxt = r_pass_cnt + PASS_ONE;
                  w_state_nxt    = ST_REQ;
               end
            end
         end
         ST_DONE: begin
            w_result_valid = 1'b1;
            if (bus.result_ready_in) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign bus.busy_out         = (r_state != ST_IDLE);
   assign bus.tile_req_out     = w_tile_req;
   assign bus.tile_idx_out     = w_tile_req ? r_pass_cnt : '0;
   assign bus.row_load_out     = w_row_load;
   assign bus.psum_to_row_out  = r_acc;
   assign bus.result_out       = r_acc;
   assign bus.result_valid_out = w_result_valid;

`ifdef PE_ROW_SEQ_PERF_EN
   logic w_stall;
   assign w_stall = (r_state == ST_REQ) && !bus.tile_valid_in;

   pe_row_seq_perf u_perf (
      .i_clk          (clk_in),
      .i_rst          (rst_in),
      .i_clear        (w_start_acc),
      .i_busy         (bus.busy_out),
      .i_stall        (w_stall),
      .o_busy_cycles  (bus.perf_busy_cycles_out),
      .o_stall_cycles (bus.perf_stall_cycles_out)
   );
`else
   logic w_unused_start;
   assign w_unused_start = w_start_acc;
`endif

endmodule

// File: tb/tb_pe_row_sequencer.sv
// tb/tb_pe_row_sequencer.sv - directed self-checking bench for pe_row_sequencer
module tb_pe_row_sequencer;
   localparam int WIDTH    = 14;
   localparam int PIPE_LAT = 11;
   localparam int PASS_W   = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pe_row_sequencer_if #(.WIDTH(WIDTH), .PASS_W(PASS_W)) bus ();

   pe_row_sequencer #(.WIDTH(WIDTH), .PIPE_LAT(PIPE_LAT), .PASS_W(PASS_W)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Row model: psum_in + row_add appears PIPE_LAT cycles after a load; junk otherwise.
   logic [WIDTH-1:0] row_add;
   logic [WIDTH-1:0] pipe [PIPE_LAT];
   always @(posedge clk) begin
      pipe[0] <= bus.row_load_out ? (bus.psum_to_row_out + row_add) : WIDTH'('h2AAA);
      for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign bus.psum_from_row_in = pipe[PIPE_LAT-1];

   logic              tv_outside;
   logic [PASS_W-1:0] idx_q[$];
   logic [WIDTH-1:0]  psum_q[$];
   int                ctl_err;

   // Starts a job at the current negedge (cycle 0) and runs until result_valid.
   task automatic run_job(input int np, input int stall, output int t_valid,
                          output logic [WIDTH-1:0] res, output int t_load);
      int   cyc;
      int   scnt;
      logic exp_load;
      idx_q.delete();
      psum_q.delete();
      ctl_err = 0;
      t_valid = -1;
      t_load  = -1;
      res     = '0;
      scnt    = 0;
      cyc     = 0;
      bus.start_in        = 1'b1;
      bus.num_pass_in     = PASS_W'(np);
      bus.tile_valid_in   = tv_outside;
      bus.result_ready_in = 1'b0;
      while (cyc < 2000 && t_valid < 0) begin
         @(negedge clk);
         cyc++;
         bus.start_in = 1'b0;
         if (bus.result_valid_out) begin
            t_valid = cyc;
            res     = bus.result_out;
         end else begin
            if (bus.tile_req_out) begin
               if (scnt < stall) begin
                  bus.tile_valid_in = 1'b0;
                  scnt++;
               end else begin
                  bus.tile_valid_in = 1'b1;
               end
            end else begin
               bus.tile_valid_in = tv_outside;
            end
            #1;
            exp_load = bus.tile_req_out && bus.tile_valid_in;
            if (bus.row_load_out !== exp_load) ctl_err++;
            if (exp_load) begin
               idx_q.push_back(bus.tile_idx_out);
               psum_q.push_back(bus.psum_to_row_out);
               if (t_load < 0) t_load = cyc;
               scnt = 0;
            end
         end
      end
   endtask

   task automatic finish_job();
      bus.result_ready_in = 1'b1;
      @(negedge clk);
      bus.result_ready_in = 1'b0;
      bus.tile_valid_in   = 1'b0;
      bus.start_in        = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.busy_out, bus.tile_req_out, bus.row_load_out, bus.result_valid_out} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b required 0000",
                  {bus.busy_out, bus.tile_req_out, bus.row_load_out, bus.result_valid_out});
      end
      n_checks++;
      if ({bus.tile_idx_out, bus.psum_to_row_out, bus.result_out} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: idx %0d psum %0d result %0d required 0",
                  bus.tile_idx_out, bus.psum_to_row_out, bus.result_out);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.busy_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy %b required 0", bus.busy_out);
      end
   endtask

   task automatic test_single_pass();
      int t_valid, t_load;
      logic [WIDTH-1:0] res;
      row_add = 5; tv_outside = 1'b0;
      run_job(1, 0, t_valid, res, t_load);
      n_checks++;
      if (t_load !== 1) begin n_fail++; $display("FAIL single_load_cycle: got %0d required 1", t_load); end
      n_checks++;
      if (t_valid !== 13) begin n_fail++; $display("FAIL single_valid_cycle: got %0d required 13", t_valid); end
      n_checks++;
      if (res !== 14'd5) begin n_fail++; $display("FAIL single_result: got %0d required 5", res); end
      n_checks++;
      if (ctl_err !== 0) begin n_fail++; $display("FAIL single_row_load: %0d bad cycles required 0", ctl_err); end
      finish_job();
   endtask

   task automatic test_multi_pass();
      int t_valid, t_load;
      logic [WIDTH-1:0] res;
      logic [PASS_W-1:0] exp_idx [3];
      logic [WIDTH-1:0]  exp_psum [3];
      exp_idx  = '{8'd0, 8'd1, 8'd2};
      exp_psum = '{14'd0, 14'd7, 14'd14};
      row_add = 7; tv_outside = 1'b1;
      run_job(3, 0, t_valid, res, t_load);
      n_checks++;
      if (idx_q.size() !== 3) begin n_fail++; $display("FAIL multi_loads: got %0d required 3", idx_q.size()); end
      for (int i = 0; i < 3 && i < idx_q.size(); i++) begin
         n_checks++;
         if (idx_q[i] !== exp_idx[i] || psum_q[i] !== exp_psum[i]) begin
            n_fail++;
            $display("FAIL multi_load%0d: idx %0d psum %0d required idx %0d psum %0d",
                     i, idx_q[i], psum_q[i], exp_idx[i], exp_psum[i]);
         end
      end
      n_checks++;
      if (t_valid !== 37 || res !== 14'd21) begin
         n_fail++;
         $display("FAIL multi_result: cycle %0d value %0d required cycle 37 value 21", t_valid, res);
      end
      n_checks++;
      if (ctl_err !== 0) begin n_fail++; $display("FAIL multi_row_load: %0d bad cycles required 0", ctl_err); end
      finish_job();
      tv_outside = 1'b0;
   endtask

   task automatic test_back_to_back();
      int t_valid, t_load;
      logic [WIDTH-1:0] res;
      row_add = 2;
      run_job(1, 0, t_valid, res, t_load);
      n_checks++;
      if (t_valid !== 13 || res !== 14'd2) begin
         n_fail++;
         $display("FAIL b2b_result: cycle %0d value %0d required cycle 13 value 2", t_valid, res);
      end
      finish_job();
   endtask

   task automatic test_stall();
      int t_valid, t_load;
      logic [WIDTH-1:0] res;
      row_add = 3;
      run_job(2, 4, t_valid, res, t_load);
      n_checks++;
      if (t_valid !== 33 || res !== 14'd6) begin
         n_fail++;
         $display("FAIL stall_result: cycle %0d value %0d required cycle 33 value 6", t_valid, res);
      end
      n_checks++;
      if (t_load !== 5) begin n_fail++; $display("FAIL stall_first_load: got %0d required 5", t_load); end
      finish_job();
`ifdef PE_ROW_SEQ_PERF_EN
      n_checks++;
      if (bus.perf_stall_cycles_out !== 32'd8) begin
         n_fail++; $display("FAIL perf_stall: got %0d required 8", bus.perf_stall_cycles_out);
      end
      n_checks++;
      if (bus.perf_busy_cycles_out !== 32'd33) begin
         n_fail++; $display("FAIL perf_busy: got %0d required 33", bus.perf_busy_cycles_out);
      end
`endif
   endtask

   task automatic test_done_hold();
      int t_valid, t_load;
      logic [WIDTH-1:0] res;
      row_add = 9;
      run_job(1, 0, t_valid, res, t_load);
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if ({bus.result_valid_out, bus.result_out} !== {1'b1, 14'd9}) begin
            n_fail++;
            $display("FAIL hold_cycle%0d: valid %b result %0d required valid 1 result 9",
                     k, bus.result_valid_out, bus.result_out);
         end
         bus.start_in    = (k == 1 || k == 2);
         bus.num_pass_in = 8'd2;
         @(negedge clk);
      end
      bus.start_in        = 1'b1;
      bus.result_ready_in = 1'b1;
      @(negedge clk);
      bus.start_in        = 1'b0;
      bus.result_ready_in = 1'b0;
      n_checks++;
      if ({bus.busy_out, bus.result_valid_out} !== 2'b00) begin
         n_fail++;
         $display("FAIL hold_release: busy %b valid %b required 0 0", bus.busy_out, bus.result_valid_out);
      end
      @(negedge clk);
      n_checks++;
      if (bus.busy_out !== 1'b0) begin
         n_fail++; $display("FAIL hold_start_ignored: busy %b required 0", bus.busy_out);
      end
   endtask

   task automatic test_zero_pass();
      int t_valid, t_load;
      logic [WIDTH-1:0] res;
      run_job(0, 0, t_valid, res, t_load);
      n_checks++;
      if (t_valid !== 1 || res !== 14'd0) begin
         n_fail++;
         $display("FAIL zero_result: cycle %0d value %0d required cycle 1 value 0", t_valid, res);
      end
      n_checks++;
      if ({bus.tile_req_out, bus.row_load_out} !== 2'b00 || idx_q.size() !== 0) begin
         n_fail++;
         $display("FAIL zero_no_fetch: req %b load %b loads %0d required none",
                  bus.tile_req_out, bus.row_load_out, idx_q.size());
      end
      finish_job();
      n_checks++;
      if (bus.busy_out !== 1'b0) begin n_fail++; $display("FAIL zero_idle: busy %b required 0", bus.busy_out); end
   endtask

   task automatic test_reset_mid();
      int loads = 0;
      int since = 0;
      int t_valid, t_load;
      logic [WIDTH-1:0] res;
      row_add = 7;
      bus.start_in    = 1'b1;
      bus.num_pass_in = 8'd3;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         bus.start_in      = 1'b0;
         bus.tile_valid_in = bus.tile_req_out;
         #1;
         if (bus.tile_req_out && bus.tile_valid_in) loads++;
         if (loads == 2) begin
            if (since == 3) break;
            since++;
         end
      end
      n_checks++;
      if (loads !== 2) begin n_fail++; $display("FAIL midrst_reach: loads %0d required 2", loads); end
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.busy_out, bus.tile_req_out, bus.row_load_out, bus.result_valid_out} !== 4'b0) begin
         n_fail++;
         $display("FAIL midrst_ctl: got %b required 0000",
                  {bus.busy_out, bus.tile_req_out, bus.row_load_out, bus.result_valid_out});
      end
      n_checks++;
      if ({bus.psum_to_row_out, bus.result_out, bus.tile_idx_out} !== '0) begin
         n_fail++;
         $display("FAIL midrst_data: psum %0d result %0d idx %0d required 0",
                  bus.psum_to_row_out, bus.result_out, bus.tile_idx_out);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.tile_valid_in = 1'b0;
      row_add = 4;
      run_job(2, 0, t_valid, res, t_load);
      n_checks++;
      if (idx_q.size() !== 2 || idx_q[0] !== 8'd0 || psum_q[0] !== 14'd0 || psum_q[1] !== 14'd4) begin
         n_fail++;
         $display("FAIL midrst_restart_loads: n %0d idx0 %0d psum0 %0d psum1 %0d required 2 0 0 4",
                  idx_q.size(), idx_q[0], psum_q[0], psum_q[1]);
      end
      n_checks++;
      if (t_valid !== 25 || res !== 14'd8) begin
         n_fail++;
         $display("FAIL midrst_restart_result: cycle %0d value %0d required cycle 25 value 8", t_valid, res);
      end
      finish_job();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start_in        = 1'b0;
      bus.num_pass_in     = '0;
      bus.tile_valid_in   = 1'b0;
      bus.result_ready_in = 1'b0;
      row_add             = '0;
      tv_outside          = 1'b0;
      test_reset();
      test_single_pass();
      test_multi_pass();
      test_back_to_back();
      test_stall();
      test_done_hold();
      test_zero_pass();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
